// File: rtl/uart_pkg.sv
// Shared UART definitions: RX frame FSM encoding and parity-type constants
// (the constants are common to the TX parity generator and the RX checker).
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } uart_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_par_chk.sv
// Combinational parity checker: flags a received parity bit that differs
// from the one the TX generator would have produced for the same word.
module uart_par_chk
    import uart_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             rx_p,
    input  logic             par_type,
    output logic             mismatch
);

    logic exp_p;

    // Even: parity bit = XOR of data; odd: its complement
    always_comb begin
        exp_p    = (par_type == PAR_ODD) ? ~^data : ^data;
        mismatch = (rx_p != exp_p);
    end

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART RX frame deserializer/checker. Advances only on bit_valid strobes,
// rebuilds the LSB-first word, checks parity and stop bit, and pulses the
// result one cycle after the stop-bit strobe.
module uart_rx_frame_check
    import uart_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             sampled_bit,
    input  logic             bit_valid,
    input  logic             parity_enable,
    input  logic             parity_type,
    output logic [WIDTH-1:0] P_DATA,
    output logic             Data_Valid,
    output logic             Par_Err,
    output logic             Stp_Err,
    output logic             Busy
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    uart_state_t      state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             pen_q, ptype_q;
    logic             par_bad;
    logic             par_mis;

    uart_par_chk #(.WIDTH(WIDTH)) u_par_chk (
        .data     (shreg),
        .rx_p     (sampled_bit),
        .par_type (ptype_q),
        .mismatch (par_mis)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: only strobed cycles move the frame forward
    always_comb begin
        state_nxt = state;
        if (bit_valid) begin
            case (state)
                IDLE:    if (!sampled_bit) state_nxt = DATA;
                DATA:    if (cnt == LAST)  state_nxt = pen_q ? PARITY : STOP;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: config latch, shift register, parity verdict, result pulses
    always_ff @(posedge CLK) begin
        if (RST) begin
            shreg      <= '0;
            cnt        <= '0;
            pen_q      <= 1'b0;
            ptype_q    <= 1'b0;
            par_bad    <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
            if (bit_valid) begin
                case (state)
                    IDLE: begin
                        if (!sampled_bit) begin
                            Busy    <= 1'b1;
                            cnt     <= '0;
                            pen_q   <= parity_enable;
                            ptype_q <= parity_type;
                            par_bad <= 1'b0;
                        end
                    end
                    DATA: begin
                        // Shifting in from the top leaves the first bit at
                        // bit 0 once WIDTH bits have arrived
                        shreg <= {sampled_bit, shreg[WIDTH-1:1]};
                        cnt   <= cnt + CW'(1);
                    end
                    PARITY: begin
                        par_bad <= pen_q & par_mis;
                    end
                    STOP: begin
                        Par_Err    <= par_bad;
                        Stp_Err    <= ~sampled_bit;
                        Data_Valid <= ~par_bad & sampled_bit;
                        if (~par_bad & sampled_bit) P_DATA <= shreg;
                        Busy       <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Self-checking bench for uart_rx_frame_check (WIDTH=8): directed table of
// frames, hand-written corner sequences, and randomized frames against a
// frame-level reference model.
module tb_uart_rx_frame_check;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         sampled_bit;
    logic         bit_valid;
    logic         parity_enable;
    logic         parity_type;
    logic [W-1:0] P_DATA;
    logic         Data_Valid;
    logic         Par_Err;
    logic         Stp_Err;
    logic         Busy;

    uart_rx_frame_check #(.WIDTH(W)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .sampled_bit   (sampled_bit),
        .bit_valid     (bit_valid),
        .parity_enable (parity_enable),
        .parity_type   (parity_type),
        .P_DATA        (P_DATA),
        .Data_Valid    (Data_Valid),
        .Par_Err       (Par_Err),
        .Stp_Err       (Stp_Err),
        .Busy          (Busy)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    // Pulse monitor on the falling edge, away from the active edge
    int cyc = 0, dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
    int dv_times[$];
    always @(negedge CLK) begin
        cyc++;
        if (Data_Valid) begin dv_cnt++; dv_times.push_back(cyc); end
        if (Par_Err) pe_cnt++;
        if (Stp_Err) se_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic strobe(input logic b);
        sampled_bit = b;
        bit_valid   = 1'b1;
        @(posedge CLK); #1;
        bit_valid   = 1'b0;
        sampled_bit = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    // Drives one full frame; returns just after the stop-bit edge.
    // flip toggles both config inputs after start accept.
    task automatic run_frame(input string nm, input logic [W-1:0] d, input bit pen,
                             input bit ptype, input bit pbit, input bit stop,
                             input int gap, input bit flip);
        parity_enable = pen;
        parity_type   = ptype;
        strobe(1'b0);
        chk({nm, " busy_at_start"}, Busy, 1);
        if (flip) begin
            parity_enable = ~pen;
            parity_type   = ~ptype;
        end
        idle(gap);
        for (int i = 0; i < W; i++) begin
            strobe(d[i]);
            idle(gap);
        end
        if (pen) begin
            strobe(pbit);
            idle(gap);
        end
        strobe(stop);
    endtask

    task automatic check_out(input string nm, input bit e_dv, input bit e_pe,
                             input bit e_se, input logic [W-1:0] e_pd);
        chk({nm, " Data_Valid"}, Data_Valid, e_dv);
        chk({nm, " Par_Err"},    Par_Err,    e_pe);
        chk({nm, " Stp_Err"},    Stp_Err,    e_se);
        chk({nm, " P_DATA"},     P_DATA,     e_pd);
        chk({nm, " Busy_end"},   Busy,       0);
    endtask

    // Reference: the transmitter's parity bit makes the total count of ones
    // even (even parity) or odd (odd parity); errors only from the frame rules.
    task automatic model(input logic [W-1:0] d, input bit pen, input bit ptype,
                         input bit pbit, input bit stop,
                         output bit e_dv, output bit e_pe, output bit e_se);
        int ones;
        bit tx_bit;
        ones   = $countones(d);
        tx_bit = ptype ? (ones % 2 == 0) : (ones % 2 == 1);
        e_pe   = pen && (pbit != tx_bit);
        e_se   = !stop;
        e_dv   = !e_pe && stop;
    endtask

    typedef struct {
        logic [W-1:0] d;
        bit           pen, ptype, pbit, stop;
        bit           dv, pe, se;
        logic [W-1:0] pd;
    } vec_t;

    vec_t tbl[9];
    logic [W-1:0] m_pdata;

    initial begin
        int d0, p0, s0;
        bit e_dv, e_pe, e_se;

        tbl[0] = '{8'hA5, 1, 0, 0, 1, 1, 0, 0, 8'hA5};  // even ok
        tbl[1] = '{8'h3C, 0, 0, 0, 1, 1, 0, 0, 8'h3C};  // no parity ok
        tbl[2] = '{8'hA5, 1, 1, 0, 1, 0, 1, 0, 8'h3C};  // odd, bad parity
        tbl[3] = '{8'hA5, 1, 1, 1, 1, 1, 0, 0, 8'hA5};  // odd ok
        tbl[4] = '{8'h3C, 0, 0, 0, 0, 0, 0, 1, 8'hA5};  // stop error
        tbl[5] = '{8'h3C, 0, 0, 0, 1, 1, 0, 0, 8'h3C};
        tbl[6] = '{8'h0F, 1, 0, 1, 0, 0, 1, 1, 8'h3C};  // both errors
        tbl[7] = '{8'h00, 1, 0, 0, 1, 1, 0, 0, 8'h00};
        tbl[8] = '{8'hFF, 1, 1, 1, 1, 1, 0, 0, 8'hFF};

        RST = 1'b1; bit_valid = 1'b0; sampled_bit = 1'b1;
        parity_enable = 1'b0; parity_type = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset P_DATA", P_DATA, 0);
        chk("reset Data_Valid", Data_Valid, 0);
        chk("reset Par_Err", Par_Err, 0);
        chk("reset Stp_Err", Stp_Err, 0);
        chk("reset Busy", Busy, 0);
        RST = 1'b0;
        idle(2);

        // Directed table
        foreach (tbl[k]) begin
            d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
            run_frame($sformatf("vec%0d", k), tbl[k].d, tbl[k].pen, tbl[k].ptype,
                      tbl[k].pbit, tbl[k].stop, k % 3, 1'b0);
            check_out($sformatf("vec%0d", k), tbl[k].dv, tbl[k].pe, tbl[k].se, tbl[k].pd);
            idle(1);
            chk($sformatf("vec%0d dv_pulses", k), dv_cnt - d0, tbl[k].dv);
            chk($sformatf("vec%0d pe_pulses", k), pe_cnt - p0, tbl[k].pe);
            chk($sformatf("vec%0d se_pulses", k), se_cnt - s0, tbl[k].se);
        end
        m_pdata = 8'hFF;

        // Back-to-back frames, a strobe on every cycle
        dv_times.delete();
        run_frame("b2b0", 8'h01, 1, 0, 1, 1, 0, 1'b0);
        check_out("b2b0", 1, 0, 0, 8'h01);
        run_frame("b2b1", 8'hFE, 1, 0, 1, 1, 0, 1'b0);
        check_out("b2b1", 1, 0, 0, 8'hFE);
        idle(1);
        chk("b2b dv_count", dv_times.size(), 2);
        if (dv_times.size() == 2)
            chk("b2b dv_spacing", dv_times[1] - dv_times[0], 11);
        m_pdata = 8'hFE;

        // Idle-line strobes change nothing
        d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
        repeat (5) begin
            strobe(1'b1);
            chk("idle Busy", Busy, 0);
        end
        idle(1);
        chk("idle pulses", (dv_cnt - d0) + (pe_cnt - p0) + (se_cnt - s0), 0);
        chk("idle P_DATA", P_DATA, 8'hFE);

        // Config flipped after start: even parity, good bit, must stay valid
        run_frame("latch", 8'h5A, 1, 0, 0, 1, 1, 1'b1);
        check_out("latch", 1, 0, 0, 8'h5A);
        // Opposite direction: odd latched, bit that is only right for odd
        run_frame("latch2", 8'h5B, 1, 1, 0, 1, 0, 1'b1);
        check_out("latch2", 1, 0, 0, 8'h5B);
        idle(1);

        // Reset after the 4th data bit
        d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
        parity_enable = 1'b1; parity_type = 1'b0;
        strobe(1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("rst_mid Busy", Busy, 0);
        chk("rst_mid P_DATA", P_DATA, 0);
        idle(3);
        chk("rst_mid pulses", (dv_cnt - d0) + (pe_cnt - p0) + (se_cnt - s0), 0);
        run_frame("after_rst", 8'h55, 1, 0, 0, 1, 0, 1'b0);
        check_out("after_rst", 1, 0, 0, 8'h55);
        idle(1);
        m_pdata = 8'h55;

        // Randomized frames against the reference model
        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] d;
            bit pen, ptype, pbit, stop, flip;
            int gap;
            d     = W'($urandom);
            pen   = 1'($urandom);
            ptype = 1'($urandom);
            pbit  = 1'($urandom);
            stop  = ($urandom_range(0, 3) != 0);
            flip  = 1'($urandom);
            gap   = $urandom_range(0, 2);
            model(d, pen, ptype, pbit, stop, e_dv, e_pe, e_se);
            if (e_dv) m_pdata = d;
            d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
            run_frame($sformatf("rnd%0d", k), d, pen, ptype, pbit, stop, gap, flip);
            check_out($sformatf("rnd%0d", k), e_dv, e_pe, e_se, m_pdata);
            idle($urandom_range(1, 2));
            chk($sformatf("rnd%0d pulses", k),
                {dv_cnt - d0, pe_cnt - p0, se_cnt - s0} != 0 ?
                    32'((dv_cnt - d0) * 4 + (pe_cnt - p0) * 2 + (se_cnt - s0)) : 32'd0,
                32'(e_dv * 4 + e_pe * 2 + e_se));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
